// File: rtl/trigger_scan_pkg.sv
// Shared types and constants for the trigger scan sequencer.
package trigger_scan_pkg;

    localparam int PAT_W   = 4;
    localparam int NUM_PAT = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_DUT_RST,
        ST_DRIVE,
        ST_FIN
    } scan_state_e;

endpackage

// File: rtl/trigger_scan_ctrl_next_pattern_sel.sv
// Finds the lowest enabled pattern at or above the current index.
module next_pattern_sel
    import trigger_scan_pkg::*;
(
    input  logic [NUM_PAT-1:0] mask,
    input  logic [PAT_W-1:0]   idx,
    output logic               found,
    output logic [PAT_W-1:0]   next_idx
);

    // Descending walk so the lowest qualifying bit is the last one written.
    always_comb begin
        found    = 1'b0;
        next_idx = '0;
        for (int i = NUM_PAT - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(idx))) begin
                found    = 1'b1;
                next_idx = PAT_W'(i);
            end
        end
    end

endmodule

// File: rtl/trigger_scan_ctrl.sv
// Steps the DUA r-bus through each enabled pattern with a reset before each
// one, and records the first pattern and drive cycle that raised trigger.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   IDLE     | waiting for start; results hold
//   SEL      | pick lowest enabled pattern >= idx, or finish
//   DUT_RST  | dut_rst low, r_out=0 for RST_CYCLES cycles
//   DRIVE    | r_out=idx for hold cycles, watching trigger_in
//   FIN      | one-cycle done pulse, then back to IDLE
module trigger_scan_ctrl
    import trigger_scan_pkg::*;
#(
    parameter int HOLD_W     = 16,
    parameter int RST_CYCLES = 2
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [15:0]        pattern_mask,
    input  logic [HOLD_W-1:0]  hold_cycles,
    input  logic               trigger_in,
    output logic [3:0]         r_out,
    output logic               dut_rst,
    output logic               busy,
    output logic               done,
    output logic               detected,
    output logic [3:0]         det_pattern,
    output logic [HOLD_W-1:0]  det_cycle
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    scan_state_e          state, state_nxt;
    logic [NUM_PAT-1:0]   mask_q, mask_nxt;
    logic [HOLD_W-1:0]    hold_last_q, hold_last_nxt;
    logic [PAT_W-1:0]     idx_q, idx_nxt;
    logic [RC_W-1:0]      rst_cnt_q, rst_cnt_nxt;
    logic [HOLD_W-1:0]    cyc_q, cyc_nxt;
    logic                 detected_nxt;
    logic [3:0]           det_pattern_nxt;
    logic [HOLD_W-1:0]    det_cycle_nxt;
    logic                 found;
    logic [PAT_W-1:0]     sel_idx;

    next_pattern_sel u_sel (
        .mask     (mask_q),
        .idx      (idx_q),
        .found    (found),
        .next_idx (sel_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            mask_q      <= '0;
            hold_last_q <= '0;
            idx_q       <= '0;
            rst_cnt_q   <= '0;
            cyc_q       <= '0;
            detected    <= 1'b0;
            det_pattern <= '0;
            det_cycle   <= '0;
        end else begin
            state       <= state_nxt;
            mask_q      <= mask_nxt;
            hold_last_q <= hold_last_nxt;
            idx_q       <= idx_nxt;
            rst_cnt_q   <= rst_cnt_nxt;
            cyc_q       <= cyc_nxt;
            detected    <= detected_nxt;
            det_pattern <= det_pattern_nxt;
            det_cycle   <= det_cycle_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        mask_nxt        = mask_q;
        hold_last_nxt   = hold_last_q;
        idx_nxt         = idx_q;
        rst_cnt_nxt     = rst_cnt_q;
        cyc_nxt         = cyc_q;
        detected_nxt    = detected;
        det_pattern_nxt = det_pattern;
        det_cycle_nxt   = det_cycle;

        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mask_nxt        = pattern_mask;
                        // Store the last drive-cycle index; a hold of 0 behaves as 1.
                        hold_last_nxt   = (hold_cycles == '0) ? '0 : hold_cycles - 1'b1;
                        detected_nxt    = 1'b0;
                        det_pattern_nxt = '0;
                        det_cycle_nxt   = '0;
                        idx_nxt         = '0;
                        state_nxt       = ST_SEL;
                    end
                end
                ST_SEL: begin
                    if (found) begin
                        idx_nxt     = sel_idx;
                        rst_cnt_nxt = RC_W'(RST_CYCLES - 1);
                        state_nxt   = ST_DUT_RST;
                    end else begin
                        state_nxt = ST_FIN;
                    end
                end
                ST_DUT_RST: begin
                    if (rst_cnt_q == '0) begin
                        cyc_nxt   = '0;
                        state_nxt = ST_DRIVE;
                    end else begin
                        rst_cnt_nxt = rst_cnt_q - 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (trigger_in) begin
                        detected_nxt    = 1'b1;
                        det_pattern_nxt = idx_q;
                        det_cycle_nxt   = cyc_q;
                        state_nxt       = ST_FIN;
                    end else if (cyc_q == hold_last_q) begin
                        if (idx_q == PAT_W'(NUM_PAT - 1)) begin
                            state_nxt = ST_FIN;
                        end else begin
                            idx_nxt   = idx_q + 1'b1;
                            state_nxt = ST_SEL;
                        end
                    end else begin
                        cyc_nxt = cyc_q + 1'b1;
                    end
                end
                ST_FIN: begin
                    state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign r_out   = (state == ST_DRIVE) ? idx_q : '0;
    assign dut_rst = (state != ST_DUT_RST);
    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_FIN);

endmodule

// File: tb/tb_trigger_scan_ctrl.sv
// Randomized bench for trigger_scan_ctrl: per-cycle output trace and final
// results compared against a schedule built from the scan rules.
module tb_trigger_scan_ctrl;

    localparam int HOLD_W     = 16;
    localparam int RST_CYCLES = 2;

    localparam logic [6:0] SEL_V  = {4'd0, 1'b1, 1'b1, 1'b0};
    localparam logic [6:0] RST_V  = {4'd0, 1'b0, 1'b1, 1'b0};
    localparam logic [6:0] FIN_V  = {4'd0, 1'b1, 1'b1, 1'b1};
    localparam logic [6:0] IDLE_V = {4'd0, 1'b1, 1'b0, 1'b0};

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [15:0]       pattern_mask = '0;
    logic [HOLD_W-1:0] hold_cycles = '0;
    logic              trigger_in;
    logic [3:0]        r_out;
    logic              dut_rst;
    logic              busy;
    logic              done;
    logic              detected;
    logic [3:0]        det_pattern;
    logic [HOLD_W-1:0] det_cycle;

    int n_chk = 0;
    int n_fail = 0;

    // DUA model: raises trigger on drive cycle tgt_k of pattern tgt, counted since its last reset.
    bit        trig_en = 1'b0;
    bit        rst_trig = 1'b0;
    logic [3:0] tgt = '0;
    logic [15:0] tgt_k = '0;
    logic [15:0] dua_cnt = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!dut_rst || (start && !busy))
            dua_cnt <= '0;
        else if (r_out == tgt)
            dua_cnt <= dua_cnt + 1'b1;
    end

    assign trigger_in = (trig_en && dut_rst && busy && (r_out == tgt) && (dua_cnt == tgt_k))
                      || (rst_trig && !dut_rst);

    trigger_scan_ctrl #(.HOLD_W(HOLD_W), .RST_CYCLES(RST_CYCLES)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .pattern_mask (pattern_mask),
        .hold_cycles  (hold_cycles),
        .trigger_in   (trigger_in),
        .r_out        (r_out),
        .dut_rst      (dut_rst),
        .busy         (busy),
        .done         (done),
        .detected     (detected),
        .det_pattern  (det_pattern),
        .det_cycle    (det_cycle)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] outs();
        return {r_out, dut_rst, busy, done};
    endfunction

    task automatic run_scan(input logic [15:0] m, input logic [15:0] h, input bit te,
                            input int tp, input int tk, input bit rt);
        logic [6:0] q[$];
        int  he;
        int  n;
        bit  hit;
        bit  exp_det;
        int  exp_pat;
        int  exp_cyc;
        he = (h == 0) ? 1 : int'(h);
        exp_det = 1'b0;
        exp_pat = 0;
        exp_cyc = 0;
        q.push_back(SEL_V);
        for (int p = 0; p < 16; p++) begin
            if (m[p]) begin
                for (int r = 0; r < RST_CYCLES; r++) q.push_back(RST_V);
                hit = te && (p == tp) && (tk < he);
                n = hit ? tk + 1 : he;
                for (int c = 0; c < n; c++) q.push_back({4'(p), 1'b1, 1'b1, 1'b0});
                if (hit) begin
                    exp_det = 1'b1;
                    exp_pat = p;
                    exp_cyc = tk;
                    break;
                end
                if (p != 15) q.push_back(SEL_V);
            end
        end
        q.push_back(FIN_V);

        trig_en  = te;
        tgt      = 4'(tp);
        tgt_k    = 16'(tk);
        rst_trig = rt;
        @(negedge clk);
        pattern_mask = m;
        hold_cycles  = h;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            chk($sformatf("trace m=%h h=%0d i=%0d", m, h, i), 32'(outs()), 32'(q[i]));
            if (i == 1 && q.size() > 3) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        chk("idle_after", 32'(outs()), 32'(IDLE_V));
        chk("detected", 32'(detected), 32'(exp_det));
        chk("det_pattern", 32'(det_pattern), 32'(exp_pat));
        chk("det_cycle", 32'(det_cycle), 32'(exp_cyc));
        rst_trig = 1'b0;
        trig_en  = 1'b0;
    endtask

    initial begin
        bit reached;
        #2;
        chk("rst_outs", 32'(outs()), 32'(IDLE_V));
        chk("rst_det", 32'({detected, det_pattern, det_cycle}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_outs", 32'(outs()), 32'(IDLE_V));

        run_scan(16'h2000, 16'd4, 1'b1, 13, 2, 1'b0);
        repeat (3) @(negedge clk);
        chk("hold_det", 32'({detected, det_pattern}), 32'({1'b1, 4'd13}));
        chk("hold_cyc", 32'(det_cycle), 32'd2);

        run_scan(16'hFFFF, 16'd3, 1'b0, 0, 0, 1'b0);
        run_scan(16'h0000, 16'd5, 1'b0, 0, 0, 1'b0);
        run_scan(16'h0500, 16'd0, 1'b0, 0, 0, 1'b0);
        run_scan(16'hFFFF, 16'd2, 1'b0, 0, 0, 1'b1);
        run_scan(16'h8001, 16'd1, 1'b1, 15, 0, 1'b0);
        run_scan(16'h0003, 16'd3, 1'b1, 0, 0, 1'b0);
        run_scan(16'h0010, 16'd3, 1'b1, 4, 3, 1'b0);

        for (int k = 0; k < 20; k++) begin
            logic [15:0] m;
            m = 16'($urandom);
            if ($urandom_range(0, 1) == 1) m = m & 16'($urandom);
            run_scan(m, 16'($urandom_range(0, 5)), bit'($urandom_range(0, 1)),
                     int'($urandom_range(0, 15)), int'($urandom_range(0, 5)), 1'b0);
        end

        // abort while pattern 5 is on the bus
        @(negedge clk);
        pattern_mask = 16'hFFFF;
        hold_cycles  = 16'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 400 && !reached; i++) begin
            if (r_out == 4'd5) reached = 1'b1;
            else @(negedge clk);
        end
        chk("abort_reach", 32'(reached), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_outs", 32'(outs()), 32'(IDLE_V));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_nodone", 32'(done), 32'd0);
        end
        chk("abort_det", 32'(detected), 32'd0);

        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort", 32'(busy), 32'd0);

        run_scan(16'h0024, 16'd2, 1'b1, 5, 1, 1'b0);

        // async reset mid-scan
        @(negedge clk);
        pattern_mask = 16'hFFFF;
        hold_cycles  = 16'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_outs", 32'(outs()), 32'(IDLE_V));
        chk("async_rst_det", 32'({detected, det_pattern, det_cycle}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_scan(16'h0100, 16'd2, 1'b0, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
